// File: rtl/bht_update_queue_pkg.sv
// Shared branch-prediction types used by the BHT update queue.
//   VLEN          : virtual address width carried with each update
//   cf_t          : control-flow type reported by the branch unit
//   bp_resolve_t  : branch-unit result {valid, pc, is_taken, cf_type}
//   bht_update_t  : BHT write request {valid, pc, taken}
package bht_update_queue_pkg;

    localparam int unsigned VLEN       = 32;
    localparam int unsigned DROP_CNT_W = 8;

    typedef enum logic [2:0] {
        NoCF,
        Branch,
        Jump,
        JumpR,
        Return
    } cf_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            is_taken;
        cf_t             cf_type;
    } bp_resolve_t;

    typedef struct packed {
        logic            valid;
        logic [VLEN-1:0] pc;
        logic            taken;
    } bht_update_t;

endpackage

// File: rtl/bht_update_queue_fifo.sv
// bht_update_fifo: storage for the BHT update queue.
//   clk_i, rst_ni  : clock, async active-low reset (pointers only)
//   flush_i        : empty the queue at the next edge
//   push_i/pop_i   : enqueue wdata_i at tail / drop head (one each per cycle)
//   overwrite_i    : rewrite the youngest entry with wdata_i (never with push_i)
//   head_o         : oldest entry, youngest_key_o: top KEY_W bits of youngest
//   count_o, empty_o, full_o : occupancy from registered pointers
// Pointers carry one extra MSB so full and empty are distinguishable.
module bht_update_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 33,
    parameter int unsigned KEY_W = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             overwrite_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [KEY_W-1:0] youngest_key_o,
    output logic [AW:0]      count_o,
    output logic             empty_o,
    output logic             full_o
);

    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    young_idx;

    assign young_idx = wr_ptr_q[AW-1:0] - AW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Payload is never visible while empty, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_i)           mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        else if (overwrite_i) mem_q[young_idx]        <= wdata_i;
    end

    assign head_o         = mem_q[rd_ptr_q[AW-1:0]];
    assign youngest_key_o = mem_q[young_idx][WIDTH-1 -: KEY_W];
    assign count_o        = wr_ptr_q - rd_ptr_q;
    assign empty_o        = (wr_ptr_q == rd_ptr_q);
    assign full_o         = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                            (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/bht_update_queue.sv
// bht_update_queue: buffers resolved conditional-branch outcomes until the
// BHT update port is free.
//   clk_i, rst_ni      : clock, async active-low reset
//   flush_i            : discard all queued updates
//   debug_mode_i       : hold queue contents, ignore new branches
//   resolved_branch_i  : branch-unit result
//   bht_busy_i         : BHT update port unavailable this cycle
//   bht_update_o       : head entry toward the BHT (valid = dequeue)
//   full_o             : queue holds DEPTH entries
//   drop_cnt_o         : saturating count of updates lost to a full queue
// DEPTH must be a power of two, at least 2.
module bht_update_queue
    import bht_update_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  debug_mode_i,
    input  bp_resolve_t           resolved_branch_i,
    input  logic                  bht_busy_i,
    output bht_update_t           bht_update_o,
    output logic                  full_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    // pc sits in the MSBs so the fifo can expose it as the youngest key.
    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
    } entry_t;

    entry_t                wdata, head;
    logic [VLEN-1:0]       young_pc;
    logic [CW-1:0]         count;
    logic                  empty, full;
    logic                  accept, deq, coalesce, push, drop;
    logic [DROP_CNT_W-1:0] drop_cnt_q;

    assign wdata.pc    = resolved_branch_i.pc;
    assign wdata.taken = resolved_branch_i.is_taken;

    assign accept = resolved_branch_i.valid && (resolved_branch_i.cf_type == Branch) &&
                    !debug_mode_i && !flush_i;

    // A flush cycle emits nothing so the discarded head is not half-consumed.
    assign deq = !empty && !bht_busy_i && !debug_mode_i && !flush_i;

    // The youngest entry is the head only when one entry is queued; if that
    // head leaves this cycle the new update must become a fresh entry.
    assign coalesce = accept && !empty && (young_pc == resolved_branch_i.pc) &&
                      !(deq && (count == CW'(1)));
    assign push     = accept && !coalesce && (!full || deq);
    assign drop     = accept && !coalesce && full && !deq;

    bht_update_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(entry_t)),
        .KEY_W (VLEN)
    ) u_fifo (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .flush_i        (flush_i),
        .push_i         (push),
        .pop_i          (deq),
        .overwrite_i    (coalesce),
        .wdata_i        (wdata),
        .head_o         (head),
        .youngest_key_o (young_pc),
        .count_o        (count),
        .empty_o        (empty),
        .full_o         (full)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)                                   drop_cnt_q <= '0;
        else if (drop && (drop_cnt_q != '1))           drop_cnt_q <= drop_cnt_q + 1'b1;
    end

    assign bht_update_o.valid = deq;
    assign bht_update_o.pc    = empty ? '0 : head.pc;
    assign bht_update_o.taken = empty ? 1'b0 : head.taken;
    assign full_o             = full;
    assign drop_cnt_o         = drop_cnt_q;

endmodule

// File: doc/bht_update_queue.md
BHT_UPDATE_QUEUE -- requirements
Module: bht_update_queue

Interface
REQ-001 Parameter DEPTH, default 4, queue entries; SHALL be a power of two, at least 2.
REQ-002 clk_i  input  1  clock, rising edge.
REQ-003 rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 flush_i  input  1  discard all queued updates.
REQ-005 debug_mode_i  input  1  core in debug mode.
REQ-006 resolved_branch_i  input  bp_resolve_t  branch-unit result: valid, pc, is_taken, cf_type.
REQ-007 bht_busy_i  input  1  BHT update port unavailable this cycle.
REQ-008 bht_update_o  output  bht_update_t  valid, pc, taken toward the BHT.
REQ-009 full_o  output  1  queue holds DEPTH entries.
REQ-010 drop_cnt_o  output  8  saturating count of dropped updates.

Function
REQ-011 Accept SHALL be: resolved_branch_i.valid, cf_type == Branch, debug_mode_i low, flush_i low; all other inputs are ignored without state change.
REQ-012 Each entry SHALL store {pc[VLEN-1:0], taken}; FIFO order, read/write pointers of log2(DEPTH)+1 bits, wrap-around via pointer MSB.
REQ-013 bht_update_o.valid SHALL be: queue non-empty, bht_busy_i low, debug_mode_i low; pc/taken SHALL come from the head entry combinationally.
REQ-014 Head SHALL dequeue in every cycle bht_update_o.valid is high.
REQ-015 Latency: update accepted at edge N into an empty queue SHALL appear on bht_update_o in cycle N+1 when not busy.
REQ-016 Coalesce: if accepted pc equals the youngest entry's pc and that entry is not dequeued this cycle, its taken SHALL be overwritten and the count SHALL not change.
REQ-017 Full with simultaneous dequeue: accepted update SHALL enqueue; count unchanged.
REQ-018 Full without dequeue and not coalescible: accepted update SHALL be dropped and drop_cnt_o SHALL increment, saturating at 255.
REQ-019 flush_i high: all entries SHALL be invalidated at the next edge; no dequeue, no enqueue, no coalesce, no drop count in that cycle; drop_cnt_o retained.
REQ-020 debug_mode_i high: existing entries SHALL be held, not drained; draining resumes the cycle debug_mode_i falls.
REQ-021 bht_busy_i high: queue SHALL hold head; enqueue and coalesce still permitted.
REQ-022 full_o SHALL equal (count == DEPTH), derived from registered pointers.
REQ-023 Never more than one enqueue and one dequeue per cycle; count SHALL stay in 0..DEPTH.

Reset
REQ-024 Asynchronous reset SHALL empty the queue: pointers 0, bht_update_o.valid 0, full_o 0, drop_cnt_o 0.
REQ-025 Entry payload storage SHALL not require reset; outputs SHALL not expose payload while empty.
REQ-026 Reset asserted mid-drain SHALL discard all entries; no update is emitted after reset deasserts until a new accept.

Structure
REQ-027 bp_resolve_t, bht_update_t, cf_t, VLEN SHALL come from the existing shared packages; no new types.
REQ-028 Queue entry struct SHALL be local to the module.
REQ-029 The storage SHALL be one sub-module, bht_update_fifo, with push/pop/overwrite-youngest ports; filtering, coalescing and drop counting stay in the top.

Verification
REQ-030 Empty queue, accept pc 0x80, taken 1, busy 0 -> bht_update_o valid next cycle with pc 0x80, taken 1, then idle.
REQ-031 busy 1, accept pcs 0x10,0x14,0x18,0x1C,0x20 (DEPTH 4) -> full_o 1 after fourth, drop_cnt_o 1; release busy -> four updates in order 0x10..0x1C on consecutive cycles.
REQ-032 busy 1, accept 0x40 taken 0 then 0x40 taken 1 -> one entry; on release single update pc 0x40 taken 1.
REQ-033 Three entries queued, flush_i with accept in same cycle -> queue empty next cycle, no update emitted, drop_cnt_o unchanged.
REQ-034 debug_mode_i high with two queued entries plus accept -> no output, accept ignored; debug low -> exactly two updates.
REQ-035 Full queue, dequeue and accept same cycle -> count stays 4, no drop; cf_type Jump accept -> ignored.
